mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Memory-access (MEM) stage load/store unit. It sits between the EX/MEM register and the MEM/WB register. It issues one data-memory transaction per load/store over a req/ack handshake, with variable wait states and a timeout. It aligns and sign/zero-extends load data, generates byte strobes for stores, and stalls the pipeline until the access completes. Non-memory instructions pass through with zero latency.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without dmem_ack before the access aborts with bus_err; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
valid_in  input  1  EX/MEM holds a valid instruction
alu_result_in  input  32  ALU result / effective address
store_data_in  input  32  rs2 value for stores
mem_read_in  input  1  load
mem_write_in  input  1  store
funct3_in  input  3  [1:0] size: 00 byte, 01 half, 1x word; [2] unsigned (loads only)
rd_in  input  5  destination register
wb_reg_file_in  input  1  register write enable
memtoreg_in  input  1  WB selects load data
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word address {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte strobes
dmem_rdata  input  32  read data, valid with ack
dmem_ack  input  1  transaction complete
alu_result_out  output  32  to MEM/WB
load_data_out  output  32  formatted load data (registered)
rd_out  output  5  to MEM/WB
wb_reg_file_out  output  1  to MEM/WB; forced 0 on error
memtoreg_out  output  1  to MEM/WB
mem_stall  output  1  hold upstream stages and MEM/WB (en = !mem_stall)
bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset values: state IDLE; dmem_req, dmem_we, bus_err, and the counter 0; dmem_addr, dmem_wdata, dmem_wstrb, and load_data_out 0. mem_stall is forced 0 while rst is high.
- Async rst mid-transaction drops dmem_req immediately. No retry is issued. Any later ack is ignored while in IDLE.
- alu_result_out, rd_out, and memtoreg_out are combinational copies of their inputs. wb_reg_file_out = wb_reg_file_in & ~err_flag.
- Access condition: acc = valid_in & (mem_read_in | mem_write_in). If both read and write are high, the access is treated as a load.
- IDLE:
  - If acc: mem_stall = 1. On the clock edge, register dmem_req = 1 and dmem_we, dmem_addr, dmem_wdata, dmem_wstrb; then go to BUSY.
  - Otherwise: mem_stall = 0 (zero-latency pass-through).
- BUSY:
  - mem_stall = 1 throughout.
  - On the edge where dmem_ack = 1: capture the formatted rdata into load_data_out (stores leave it at 0), drop dmem_req, go to DONE.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES without ack: drop dmem_req, set err_flag, load_data_out = 0, go to DONE.
  - The counter clears on entry to BUSY.
- DONE:
  - mem_stall = 0, so MEM/WB captures this cycle.
  - bus_err = err_flag for this single cycle.
  - Next edge: go to IDLE and clear err_flag.
- Latency: ack sampled at the first BUSY edge gives 2 stall cycles plus the DONE cycle. Each extra wait state adds one stall cycle.
- Load format, with lane = addr[1:0]:
  - Byte: rdata byte[lane], sign-extended, or zero-extended when funct3[2] = 1.
  - Half: rdata half[addr[1]], sign- or zero-extended by funct3[2].
  - Word: rdata unchanged.
- Store format:
  - Byte: wstrb = 4'b0001 << lane; wdata = {4{data[7:0]}}.
  - Half: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{data[15:0]}}.
  - Word: wstrb = 4'b1111; wdata = data.
  - Loads: wstrb = 0.
- Without the optional feature, misaligned low address bits are ignored: half ignores addr[0]; word ignores addr[1:0].
- dmem_ack outside BUSY is ignored.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: adds output misalign_exc (1 bit, reset 0). A misaligned half (addr[0] = 1) or word (addr[1:0] ≠ 0) access issues no dmem_req. The FSM goes IDLE→DONE with one stall cycle. misalign_exc pulses in DONE and wb_reg_file_out is forced 0.
- Undefined: no port; low address bits are ignored as above.

Test Plan:
- ADD with wb = 1, rd = 5, alu = 0x2A, no memory op → mem_stall stays 0; same-cycle outputs alu_result_out = 0x2A, rd_out = 5.
- SW 0xDEADBEEF at 0x100, ack on 3rd BUSY cycle → dmem_addr 0x100, wstrb 1111, we = 1, req high for 3 cycles, mem_stall high for 4 cycles, then DONE.
- LB at 0x103 with rdata 0x80FF1234 → load_data_out 0xFFFFFF80; LBU at the same address → 0x00000080.
- LH at 0x102 with rdata 0x80010000 → 0xFFFF8001; SH 0x0000ABCD at 0x102 → wstrb 1100, wdata 0xABCDABCD.
- TIMEOUT_CYCLES = 4, load with no ack → req drops after 4 BUSY cycles; DONE shows bus_err = 1, load_data_out = 0, wb_reg_file_out = 0.
- rst pulsed in the 2nd BUSY cycle → dmem_req and mem_stall drop immediately; a late ack is ignored; the next LW completes normally. With MISALIGN_TRAP_EN: LW at 0x102 → no dmem_req, misalign_exc = 1 in DONE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one dmem req/ack transaction per load/store, with a
// timeout and load/store lane formatting. Optional MISALIGN_TRAP_EN adds misalign_exc.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic        wb_reg_file_in,
  input  logic        memtoreg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  rd_out,
  output logic        wb_reg_file_out,
  output logic        memtoreg_out,
  output logic        mem_stall,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_exc,
`endif
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Access attributes kept for formatting the read data at ack time.
  typedef struct packed {
    logic       load;
    logic [1:0] lane;
    logic [2:0] f3;
  } acc_t;

  state_t           state, nxt;
  acc_t             acc_q;
  logic [CNT_W-1:0] cnt;
  logic             err_flag, mis_flag;
  logic             acc, is_store, trap, to_hit;
  logic [1:0]       lane;
  logic [3:0]       wstrb_c;
  logic [31:0]      wdata_c, ld_fmt;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign acc      = valid_in & (mem_read_in | mem_write_in);
  assign is_store = mem_write_in & ~mem_read_in;
  assign lane     = alu_result_in[1:0];
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  assign trap = acc & (funct3_in[1] ? (lane != 2'b00) : (funct3_in[0] & lane[0]));
  assign misalign_exc = (state == DONE) & mis_flag;
`else
  assign trap = 1'b0;
`endif

  assign alu_result_out  = alu_result_in;
  assign rd_out          = rd_in;
  assign memtoreg_out    = memtoreg_in;
  assign wb_reg_file_out = wb_reg_file_in & ~err_flag & ~mis_flag;

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = store_data_in;
    if (!funct3_in[1] && funct3_in[0]) begin
      wstrb_c = 4'b0011 << {lane[1], 1'b0};
      wdata_c = {2{store_data_in[15:0]}};
    end else if (!funct3_in[1]) begin
      wstrb_c = 4'b0001 << lane;
      wdata_c = {4{store_data_in[7:0]}};
    end
    if (!is_store) wstrb_c = 4'b0000;
  end

  always_comb begin
    rd_byte = dmem_rdata[{acc_q.lane, 3'b000} +: 8];
    rd_half = dmem_rdata[{acc_q.lane[1], 4'b0000} +: 16];
    if (acc_q.f3[1])      ld_fmt = dmem_rdata;
    else if (acc_q.f3[0]) ld_fmt = {{16{~acc_q.f3[2] & rd_half[15]}}, rd_half};
    else                  ld_fmt = {{24{~acc_q.f3[2] & rd_byte[7]}}, rd_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = trap ? DONE : BUSY;
      BUSY:    if (dmem_ack || to_hit) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE:    mem_stall = acc;
      BUSY:    mem_stall = 1'b1;
      DONE:    bus_err   = err_flag;
      default: ;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      load_data_out <= '0;
      acc_q         <= '0;
      cnt           <= '0;
      err_flag      <= 1'b0;
      mis_flag      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          if (trap) begin
            mis_flag      <= 1'b1;
            load_data_out <= '0;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem_wdata <= wdata_c;
            dmem_wstrb <= wstrb_c;
            acc_q      <= '{load: ~is_store, lane: lane, f3: funct3_in};
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            load_data_out <= acc_q.load ? ld_fmt : 32'h0;
          end else if (to_hit) begin
            dmem_req      <= 1'b0;
            err_flag      <= 1'b1;
            load_data_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          mis_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
